// File: rtl/serial_add_sequencer.sv
// Multi-cycle adder: captures one operand set, adds it SLICE_W bits per cycle through
// one shared ripple slice, then holds the registered result until the consumer takes it.

module serial_add_slice #(
  parameter int W = 8
) (
  input  logic [W-1:0] i_a,
  input  logic [W-1:0] i_b,
  input  logic         i_cin,
  output logic [W-1:0] o_sum,
  output logic         o_cout
);

  logic [W:0] w_c;

  // Bit-level ripple chain for one slice.
  always_comb begin
    w_c    = '0;
    o_sum  = '0;
    w_c[0] = i_cin;
    for (int i = 0; i < W; i++) begin
      o_sum[i]  = i_a[i] ^ i_b[i] ^ w_c[i];
      w_c[i+1]  = (i_a[i] & i_b[i]) | (w_c[i] & (i_a[i] ^ i_b[i]));
    end
    o_cout = w_c[W];
  end

endmodule

module serial_add_sequencer #(
  parameter int DATA_W  = 64,
  parameter int SLICE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  input  logic              cin,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] sum,
  output logic              cout,
  output logic              busy
);

  localparam int N     = DATA_W / SLICE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t r_state;
  state_t w_state_next;

  logic [DATA_W-1:0]  r_a;
  logic [DATA_W-1:0]  r_b;
  logic               r_carry;
  logic [DATA_W-1:0]  r_work;
  logic [IDX_W-1:0]   r_idx;
  logic [DATA_W-1:0]  r_sum;
  logic               r_cout;

  logic               w_accept;
  logic               w_last;
  logic [SLICE_W-1:0] w_a_slice;
  logic [SLICE_W-1:0] w_b_slice;
  logic [SLICE_W-1:0] w_slice_sum;
  logic               w_slice_cout;
  logic [DATA_W-1:0]  w_work_next;

  assign w_accept  = (r_state == S_IDLE) && in_valid;
  assign w_last    = (r_state == S_RUN) && (r_idx == LAST_IDX);
  assign w_a_slice = r_a[r_idx*SLICE_W +: SLICE_W];
  assign w_b_slice = r_b[r_idx*SLICE_W +: SLICE_W];

  serial_add_slice #(.W(SLICE_W)) u_slice (
    .i_a    (w_a_slice),
    .i_b    (w_b_slice),
    .i_cin  (r_carry),
    .o_sum  (w_slice_sum),
    .o_cout (w_slice_cout)
  );

  // Working sum with the current slice merged in.
  always_comb begin
    w_work_next = r_work;
    w_work_next[r_idx*SLICE_W +: SLICE_W] = w_slice_sum;
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state decode; DONE always returns through IDLE so no same-cycle re-accept.
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      S_IDLE: begin
        if (in_valid) w_state_next = S_RUN;
        else          w_state_next = S_IDLE;
      end
      S_RUN: begin
        if (r_idx == LAST_IDX) w_state_next = S_DONE;
        else                   w_state_next = S_RUN;
      end
      S_DONE: begin
        if (out_ready) w_state_next = S_IDLE;
        else           w_state_next = S_DONE;
      end
      default: w_state_next = S_IDLE;
    endcase
  end

  // Operand capture, slice stepping and result load.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_a     <= '0;
      r_b     <= '0;
      r_carry <= 1'b0;
      r_work  <= '0;
      r_idx   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else if (w_accept) begin
      r_a     <= a;
      r_b     <= b;
      r_carry <= cin;
      r_work  <= '0;
      r_idx   <= '0;
    end else if (r_state == S_RUN) begin
      r_work  <= w_work_next;
      r_carry <= w_slice_cout;
      if (r_idx != LAST_IDX) begin
        r_idx <= r_idx + 1'b1;
      end
      if (w_last) begin
        r_sum  <= w_work_next;
        r_cout <= w_slice_cout;
      end
    end
  end

  assign in_ready  = (r_state == S_IDLE);
  assign out_valid = (r_state == S_DONE);
  assign busy      = (r_state != S_IDLE);
  assign sum       = r_sum;
  assign cout      = r_cout;

endmodule

// File: tb/tb_serial_add_sequencer.sv
// Directed and randomized checks of serial_add_sequencer at default parameters.

module tb_serial_add_sequencer;

  localparam int DATA_W = 64;

  logic              clk = 1'b0;
  logic              rst = 1'b0;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [DATA_W-1:0] a = '0;
  logic [DATA_W-1:0] b = '0;
  logic              cin = 1'b0;
  logic              out_valid;
  logic              out_ready = 1'b0;
  logic [DATA_W-1:0] sum;
  logic              cout;
  logic              busy;

  int vectors = 0;
  int miscompares = 0;

  serial_add_sequencer #(.DATA_W(DATA_W), .SLICE_W(8)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    step(); step();
    rst = 1'b0;
    vectors++; if (in_ready !== 1'b1)  begin miscompares++; $display("FAIL reset_in_ready got %b want 1", in_ready); end
    vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL reset_out_valid got %b want 0", out_valid); end
    vectors++; if (busy !== 1'b0)      begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (sum !== 64'h0)      begin miscompares++; $display("FAIL reset_sum got %h want 0", sum); end
    vectors++; if (cout !== 1'b0)      begin miscompares++; $display("FAIL reset_cout got %b want 0", cout); end
  endtask

  task automatic test_carry_ripple();
    a = 64'hFFFF_FFFF_FFFF_FFFF; b = 64'h1; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ripple_ready got %b want 1", in_ready); end
    step();
    in_valid = 1'b0;
    for (int c = 1; c <= 9; c++) begin
      vectors++;
      if (busy !== 1'b1) begin miscompares++; $display("FAIL ripple_busy cyc %0d got %b want 1", c, busy); end
      vectors++;
      if (out_valid !== ((c == 9) ? 1'b1 : 1'b0)) begin
        miscompares++; $display("FAIL ripple_out_valid cyc %0d got %b want %b", c, out_valid, (c == 9));
      end
      if (c == 9) begin
        vectors++; if (sum !== 64'h0) begin miscompares++; $display("FAIL ripple_sum got %h want 0", sum); end
        vectors++; if (cout !== 1'b1) begin miscompares++; $display("FAIL ripple_cout got %b want 1", cout); end
      end
      step();
    end
    vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL ripple_busy_after got %b want 0", busy); end
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL ripple_ready_after got %b want 1", in_ready); end
  endtask

  task automatic test_full_chain();
    int lat;
    a = 64'h0123_4567_89AB_CDEF; b = 64'hFEDC_BA98_7654_3210; cin = 1'b1;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    vectors++; if (lat != 9)        begin miscompares++; $display("FAIL chain_latency got %0d want 9", lat); end
    vectors++; if (sum !== 64'h0)   begin miscompares++; $display("FAIL chain_sum got %h want 0", sum); end
    vectors++; if (cout !== 1'b1)   begin miscompares++; $display("FAIL chain_cout got %b want 1", cout); end
    step();
  endtask

  task automatic test_stall();
    int lat;
    a = 64'd5; b = 64'd7; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b0;
    step();
    in_valid = 1'b0; a = 64'hFF; b = 64'h1234; cin = 1'b1;
    lat = 1;
    while (out_valid !== 1'b1 && lat < 20) begin step(); lat++; end
    vectors++; if (lat != 9) begin miscompares++; $display("FAIL stall_latency got %0d want 9", lat); end
    for (int k = 0; k < 5; k++) begin
      in_valid = (k % 2 == 0) ? 1'b1 : 1'b0;
      vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_valid k %0d got %b want 1", k, out_valid); end
      vectors++; if (in_ready !== 1'b0)  begin miscompares++; $display("FAIL stall_ready k %0d got %b want 0", k, in_ready); end
      vectors++; if (sum !== 64'd12)     begin miscompares++; $display("FAIL stall_sum k %0d got %h want c", k, sum); end
      vectors++; if (cout !== 1'b0)      begin miscompares++; $display("FAIL stall_cout k %0d got %b want 0", k, cout); end
      step();
    end
    vectors++; if (out_valid !== 1'b1) begin miscompares++; $display("FAIL stall_hold got %b want 1", out_valid); end
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL no_same_cycle_ready got %b want 1", in_ready); end
    vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL no_same_cycle_busy got %b want 0", busy); end
    vectors++; if (sum !== 64'd12)    begin miscompares++; $display("FAIL idle_hold_sum got %h want c", sum); end
  endtask

  task automatic test_reset_abort();
    a = 64'd3; b = 64'd4; cin = 1'b0;
    in_valid = 1'b1; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    step(); step(); step();
    rst = 1'b1;
    step();
    rst = 1'b0;
    vectors++; if (in_ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready got %b want 1", in_ready); end
    vectors++; if (busy !== 1'b0)     begin miscompares++; $display("FAIL abort_busy got %b want 0", busy); end
    vectors++; if (sum !== 64'h0)     begin miscompares++; $display("FAIL abort_sum got %h want 0", sum); end
    vectors++; if (cout !== 1'b0)     begin miscompares++; $display("FAIL abort_cout got %b want 0", cout); end
    for (int c = 0; c < 15; c++) begin
      vectors++; if (out_valid !== 1'b0) begin miscompares++; $display("FAIL abort_no_valid cyc %0d got %b want 0", c, out_valid); end
      step();
    end
  endtask

  task automatic test_back_to_back();
    logic [DATA_W:0] q[$];
    logic [DATA_W:0] exp_v;
    int last_acc;
    int results;
    logic acc;
    last_acc = -1; results = 0;
    a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom_range(1, 0));
    in_valid = 1'b1; out_ready = 1'b1;
    for (int c = 0; c < 100 && results < 5; c++) begin
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++; $display("FAIL b2b_unexpected got %h want none", {cout, sum});
        end else begin
          exp_v = q.pop_front();
          if ({cout, sum} !== exp_v) begin miscompares++; $display("FAIL b2b_result got %h want %h", {cout, sum}, exp_v); end
        end
        results++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back({1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin});
        if (last_acc >= 0) begin
          vectors++;
          if (c - last_acc != 10) begin miscompares++; $display("FAIL b2b_period got %0d want 10", c - last_acc); end
        end
        last_acc = c;
      end
      step();
      if (acc) begin
        a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom_range(1, 0));
      end
    end
    vectors++; if (results < 5) begin miscompares++; $display("FAIL b2b_timeout got %0d want 5", results); end
    in_valid = 1'b0;
    for (int c = 0; c < 20 && q.size() > 0; c++) begin
      if (out_valid === 1'b1) begin
        exp_v = q.pop_front();
        vectors++;
        if ({cout, sum} !== exp_v) begin miscompares++; $display("FAIL b2b_drain got %h want %h", {cout, sum}, exp_v); end
      end
      step();
    end
    vectors++; if (q.size() != 0) begin miscompares++; $display("FAIL b2b_drain_timeout got %0d want 0", q.size()); end
  endtask

  task automatic test_random();
    logic [DATA_W:0] q[$];
    logic [DATA_W:0] exp_v;
    int nacc;
    int results;
    logic acc;
    nacc = 0; results = 0;
    for (int c = 0; c < 40000 && results < 1000; c++) begin
      vectors++;
      if (out_valid === 1'b1 && in_ready === 1'b1) begin
        miscompares++; $display("FAIL rand_exclusive cyc %0d got both high want not both", c);
      end
      if (out_valid === 1'b1 && out_ready === 1'b1) begin
        vectors++;
        if (q.size() == 0) begin
          miscompares++; $display("FAIL rand_unexpected got %h want none", {cout, sum});
        end else begin
          exp_v = q.pop_front();
          if ({cout, sum} !== exp_v) begin miscompares++; $display("FAIL rand_result %0d got %h want %h", results, {cout, sum}, exp_v); end
        end
        results++;
      end
      acc = in_valid && in_ready;
      if (acc) begin
        q.push_back({1'b0, a} + {1'b0, b} + {{DATA_W{1'b0}}, cin});
        nacc++;
      end
      step();
      a = {$urandom, $urandom}; b = {$urandom, $urandom}; cin = 1'($urandom_range(1, 0));
      in_valid  = (nacc < 1000) && ($urandom_range(3, 0) != 0);
      out_ready = 1'($urandom_range(1, 0));
    end
    vectors++; if (results != 1000) begin miscompares++; $display("FAIL rand_count got %0d want 1000", results); end
    in_valid = 1'b0; out_ready = 1'b1;
  endtask

  initial begin
    test_reset();
    test_carry_ripple();
    test_full_chain();
    test_stall();
    test_reset_abort();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/serial_add_sequencer.md
SERIAL_ADD_SEQUENCER -- requirements
Module: serial_add_sequencer

Interface
REQ-001 The block SHALL have parameter DATA_W, default 64, meaning operand/result width in bits.
REQ-002 The block SHALL have parameter SLICE_W, default 8, meaning bits added per cycle; DATA_W SHALL be an integer multiple of SLICE_W, and N = DATA_W/SLICE_W.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: synchronous, active-high reset.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the requester presents an operand set.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept an operand set.
REQ-007 The block SHALL have ports a and b, input, DATA_W bits each: the addends.
REQ-008 The block SHALL have port cin, input, 1 bit: carry into bit 0.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the result on sum/cout is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer takes the result.
REQ-011 The block SHALL have port sum, output, DATA_W bits: registered result, a+b+cin modulo 2^DATA_W.
REQ-012 The block SHALL have port cout, output, 1 bit: registered carry out of bit DATA_W-1.
REQ-013 The block SHALL have port busy, output, 1 bit: high whenever the state is not IDLE.

Function
REQ-014 The block SHALL implement states IDLE, RUN and DONE.
REQ-015 The block SHALL drive in_ready=1 only in IDLE and out_valid=1 only in DONE, both as decodes of registered state.
REQ-016 On in_valid&&in_ready in IDLE, the block SHALL capture a, b and cin, clear slice index idx to 0, and enter RUN.
REQ-017 After capture, the block SHALL ignore changes on a, b and cin until the next accept.
REQ-018 In RUN, the block SHALL add one SLICE_W-bit slice per cycle (slice idx of the captured a and b plus the carry register) using a single SLICE_W-bit ripple adder instance, store the slice sum into working bits [idx*SLICE_W +: SLICE_W], update the carry register with the slice carry out, and increment idx.
REQ-019 When slice N-1 completes, the block SHALL load the working sum into sum and the final carry into cout, and enter DONE; idx SHALL NOT wrap or run past N-1.
REQ-020 With accept in cycle 0, the block SHALL process slices 0..N-1 in cycles 1..N and assert out_valid from cycle N+1 (cycle 9 at default parameters).
REQ-021 sum and cout SHALL change only on entry to DONE or on reset; they SHALL hold the last result while IDLE and RUN, and hold stable throughout DONE.
REQ-022 In DONE, the block SHALL remain there with outputs unchanged while out_ready=0, and on out_valid&&out_ready SHALL return to IDLE.
REQ-023 The block SHALL NOT accept a new operand set in the same cycle as the result handshake; the minimum accept-to-accept period SHALL be N+2 cycles.
REQ-024 The block SHALL ignore in_valid outside IDLE and out_ready outside DONE.
REQ-025 At cin=1 with all-ones operands, the block SHALL propagate carry across every slice boundary with no lost or duplicated carry.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL enter IDLE and clear idx, the carry register, working sum, sum and cout to 0, regardless of state.
REQ-027 After reset the outputs SHALL be in_ready=1, out_valid=0, busy=0, sum=0 and cout=0.
REQ-028 A reset during RUN or DONE SHALL abort the operation, discard the partial result and produce no out_valid pulse.
REQ-029 rst SHALL take priority over any simultaneous handshake.

Verification
REQ-030 Accept a=0xFFFF_FFFF_FFFF_FFFF, b=1, cin=0 with out_ready=1 -> out_valid in cycle 9, sum=0, cout=1, busy high in cycles 1-9.
REQ-031 Accept a=0x0123_4567_89AB_CDEF, b=0xFEDC_BA98_7654_3210, cin=1 -> sum=0, cout=1, exercising the full carry chain.
REQ-032 Accept a=5, b=7, cin=0, then change a to 0xFF during RUN and hold out_ready=0 for 5 cycles -> sum=12, cout=0 held stable with out_valid=1 and in_ready=0 for all 5 cycles; in_valid pulses during this time are ignored.
REQ-033 Assert rst for one cycle at cycle 4 after an accept -> next cycle in_ready=1, busy=0, sum=0, cout=0, and no out_valid thereafter until a new accept.
REQ-034 Hold in_valid=1 and out_ready=1 with a new random operand each accept -> accepts occur every 10 cycles and every result matches the reference a+b+cin.
REQ-035 Run 1000 random operand sets with random out_ready stalls -> every result is correct and in-order, and out_valid and in_ready are never both high in the same cycle.
